// File: rtl/mat_pkg.sv
// mat_pkg: shared matrix dimensions, word width and loader state encoding
package mat_pkg;
    localparam int ANCHOPALABRA = 32;
    localparam int DIM = 3;
    localparam int ADDR_W = $clog2(DIM*DIM-1)+1;
    typedef enum logic [1:0] {IDLE, LOAD_M1, LOAD_M2, DONE} state_t;
endpackage

// File: rtl/load_addr_cnt.sv
// load_addr_cnt: modulo-MOD element counter with clear, enable and terminal count
module load_addr_cnt #(
    parameter int MOD = 9,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);
    assign tc = count == W'(MOD-1);
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= tc ? '0 : count + W'(1);
endmodule

// File: rtl/mat_loader.sv
// mat_loader: streams M1 then M2 into their RAM pairs, then pulses signal
module mat_loader #(
    parameter int ANCHOPALABRA = mat_pkg::ANCHOPALABRA,
    parameter int DIM = mat_pkg::DIM,
    localparam int ADDR_W = $clog2(DIM*DIM-1)+1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ANCHOPALABRA-1:0] in_real,
    input  logic [ANCHOPALABRA-1:0] in_imag,
    output logic [ANCHOPALABRA-1:0] data_real,
    output logic [ANCHOPALABRA-1:0] data_imag,
    output logic [ADDR_W-1:0]       write_addr,
    output logic                    we_m1,
    output logic                    we_m2,
    output logic                    busy,
    output logic                    signal
);
    import mat_pkg::*;
    state_t state, next_state;
    logic accept, last;
    logic [ADDR_W-1:0] count;
    load_addr_cnt #(.MOD(DIM*DIM), .W(ADDR_W)) u_cnt (
        .clk(clk), .rst(rst), .clr(~in_ready), .en(accept), .count(count), .tc(last)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next_state;
    always_comb
        next_state = state == IDLE    ? (load_start ? LOAD_M1 : IDLE) :
                     state == LOAD_M1 ? (accept && last ? LOAD_M2 : LOAD_M1) :
                     state == LOAD_M2 ? (accept && last ? DONE : LOAD_M2) : IDLE;
    always_comb begin
        in_ready = state == LOAD_M1 || state == LOAD_M2;
        accept = in_valid && in_ready;
    end
    // last M2 write strobe lands in DONE, so signal follows it by one cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            data_real <= '0;
            data_imag <= '0;
            write_addr <= '0;
            we_m1 <= 1'b0;
            we_m2 <= 1'b0;
            busy <= 1'b0;
            signal <= 1'b0;
        end else begin
            data_real <= accept ? in_real : data_real;
            data_imag <= accept ? in_imag : data_imag;
            write_addr <= accept ? count : write_addr;
            we_m1 <= accept && state == LOAD_M1;
            we_m2 <= accept && state == LOAD_M2;
            busy <= next_state != IDLE;
            signal <= state == DONE;
        end
endmodule

// File: tb/tb_mat_loader.sv
// tb_mat_loader: randomized and directed checks of mat_loader against a beat-count model
module tb_mat_loader;
    import mat_pkg::*;
    localparam int W = ANCHOPALABRA;
    localparam int N = DIM*DIM;
    localparam int AW = ADDR_W;

    logic clk = 0, rst = 1, load_start = 0, in_valid = 0;
    logic [W-1:0] in_real = '0, in_imag = '0;
    logic in_ready, we_m1, we_m2, busy, signal;
    logic [W-1:0] data_real, data_imag;
    logic [AW-1:0] write_addr;

    mat_loader dut (
        .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
        .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .data_real(data_real), .data_imag(data_imag), .write_addr(write_addr),
        .we_m1(we_m1), .we_m2(we_m2), .busy(busy), .signal(signal)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    int phase, n, sig_seen, sig_exp;
    logic m_we1, m_we2, m_sig, m_busy;
    logic [AW-1:0] m_addr;
    logic [W-1:0] m_re, m_im;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        phase = 0; n = 0;
        m_we1 = 0; m_we2 = 0; m_sig = 0; m_busy = 0;
        m_addr = '0; m_re = '0; m_im = '0;
    endtask

    // phase 0 idle, 1 loading beats 0..2N-1 (first N to M1), 2 completion cycle
    task automatic model_step();
        bit acc;
        acc = phase == 1 && in_valid;
        m_we1 = acc && n < N;
        m_we2 = acc && n >= N;
        if (acc) begin
            m_addr = AW'(n % N);
            m_re = in_real;
            m_im = in_imag;
        end
        m_sig = phase == 2;
        if (m_sig) sig_exp++;
        if (phase == 0) begin
            if (load_start) begin phase = 1; n = 0; end
        end else if (phase == 1) begin
            if (acc) begin
                n++;
                if (n == 2*N) phase = 2;
            end
        end else phase = 0;
        m_busy = phase != 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".in_ready"}, 64'(in_ready), 64'(phase == 1));
        check({tag, ".we_m1"}, 64'(we_m1), 64'(m_we1));
        check({tag, ".we_m2"}, 64'(we_m2), 64'(m_we2));
        check({tag, ".addr"}, 64'(write_addr), 64'(m_addr));
        check({tag, ".real"}, 64'(data_real), 64'(m_re));
        check({tag, ".imag"}, 64'(data_imag), 64'(m_im));
        check({tag, ".busy"}, 64'(busy), 64'(m_busy));
        check({tag, ".signal"}, 64'(signal), 64'(m_sig));
        check({tag, ".excl"}, 64'(we_m1 && we_m2), 64'(0));
    endtask

    task automatic step(input string tag, input logic st, input logic v, input logic [W-1:0] re, input logic [W-1:0] im);
        load_start = st; in_valid = v; in_real = re; in_imag = im;
        @(negedge clk);
        check_outputs(tag);
        if (signal) sig_seen++;
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string tag);
        load_start = 0; in_valid = 0;
        rst = 1;
        model_reset();
        #1 check_outputs({tag, ".async"});
        @(negedge clk) check_outputs({tag, ".hold"});
        @(posedge clk); #1 rst = 0;
    endtask

    task automatic beats_until_idle(input string tag, input int pattern, input bit restart);
        int k, c;
        bit v;
        k = 0; c = 0;
        while (phase != 0 && c < 400) begin
            v = pattern == 0 ? 1'b1 : pattern == 1 ? (c % 3 == 0) : ($urandom_range(0, 3) != 0);
            step(tag, restart && n >= N, v, W'(k), W'(-k));
            if (v && phase != 0 && n > 0) k = n;
            c++;
        end
        check({tag, ".bound"}, 64'(phase), 64'(0));
    endtask

    initial begin
        sig_seen = 0; sig_exp = 0;
        model_reset();
        @(posedge clk); #1;
        do_reset("reset");
        for (int i = 0; i < 5; i++) step("idle", 0, 0, '0, '0);

        step("b2b.start", 1, 0, '0, '0);
        for (int k = 0; k < 2*N; k++) step("b2b", 0, 1, W'(k), W'(-k));
        for (int i = 0; i < 3; i++) step("b2b.tail", 0, 0, '0, '0);
        check("b2b.signal_count", 64'(sig_seen), 64'(1));

        step("stall.start", 1, 0, '0, '0);
        beats_until_idle("stall", 1, 0);
        step("stall.tail", 0, 0, '0, '0);
        step("stall.tail", 0, 0, '0, '0);

        step("midrst.start", 1, 0, '0, '0);
        for (int k = 0; k < 5; k++) step("midrst", 0, 1, W'(100 + k), W'(-(100 + k)));
        do_reset("midrst.rst");
        step("midrst.idle", 0, 1, W'(7), W'(7));
        step("midrst.restart", 1, 0, '0, '0);
        beats_until_idle("midrst.reload", 0, 0);
        step("midrst.tail", 0, 0, '0, '0);
        step("midrst.tail", 0, 0, '0, '0);

        sig_seen = 0; sig_exp = 0;
        step("ignore.start", 1, 0, '0, '0);
        beats_until_idle("ignore", 2, 1);
        for (int i = 0; i < 3; i++) step("ignore.tail", 0, 0, '0, '0);
        check("ignore.signal_count", 64'(sig_seen), 64'(1));

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset("rand.rst");
            else step("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, W'($urandom), W'($urandom));
        end
        for (int i = 0; i < 40; i++) step("rand.drain", 0, 0, '0, '0);
        check("total.signal_count", 64'(sig_seen), 64'(sig_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
